// File: rtl/adder_if.sv
// Handshake bundle for the registered adder: operand side (in_*, a, b)
// and result side (out_*, s, c) plus the carry-event counter.
interface adder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic [CNT_W-1:0] carry_count;

  // Upstream/downstream environment around the adder.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, c, carry_count
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, c, carry_count
  );
endinterface

// File: rtl/adder.sv
// Registered WIDTH-bit adder (half adder at WIDTH=1) with a one-entry
// result register, valid/ready handshakes on both sides and a saturating
// count of accepted transactions that produced a carry.
module adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  adder_if.slave bus
);

  // The only control state: whether the result register holds a live result.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;
  logic [CNT_W-1:0] count_reg;
  logic             accept;
  logic             consume;
  logic [WIDTH:0]   sum_full;

  // Ready whenever the result slot is free or is being drained this cycle;
  // this gives full throughput with a single result register.
  assign bus.in_ready = (state_reg == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = (state_reg == FULL) && bus.out_ready;

  // Carry is simply the extra top bit of the widened sum.
  assign sum_full = {1'b0, bus.a} + {1'b0, bus.b};

  // Next-state: accept always (re)fills the slot; a bare consume empties it.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = FULL;
    end else if (consume) begin
      state_next = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result register: loads on accept, otherwise holds (also after consume).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
      c_reg <= 1'b0;
    end else if (accept) begin
      s_reg <= sum_full[WIDTH-1:0];
      c_reg <= sum_full[WIDTH];
    end
  end

  // Carry-event counter, saturating at all-ones; independent of consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (accept && sum_full[WIDTH] && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.out_valid   = (state_reg == FULL);
  assign bus.s           = s_reg;
  assign bus.c           = c_reg;
  assign bus.carry_count = count_reg;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed scenarios on a 1-bit and a 4-bit
// (2-bit counter) instance, then randomized traffic against a reference model.
module tb_adder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model state (plain integers).
  int m1_v, m1_s, m1_c, m1_n;
  int m4_v, m4_s, m4_c, m4_n;

  always #5 clk = ~clk;

  adder_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  adder_if #(.WIDTH(4), .CNT_W(2)) bus4 ();

  adder #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  adder #(.WIDTH(4), .CNT_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  task automatic idle_inputs();
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #2;
    rst = 1'b0;
    m1_v = 0; m1_s = 0; m1_c = 0; m1_n = 0;
    m4_v = 0; m4_s = 0; m4_c = 0; m4_n = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if ({bus1.out_valid, bus1.c, bus1.s, bus1.carry_count, bus1.in_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_w1: got v=%b c=%b s=%h n=%0d rdy=%b, want 0 0 0 0 1",
               bus1.out_valid, bus1.c, bus1.s, bus1.carry_count, bus1.in_ready);
    end
    checks++;
    if ({bus4.out_valid, bus4.c, bus4.s, bus4.carry_count, bus4.in_ready} !== {1'b0, 1'b0, 4'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_w4: got v=%b c=%b s=%h n=%0d rdy=%b, want 0 0 0 0 1",
               bus4.out_valid, bus4.c, bus4.s, bus4.carry_count, bus4.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // Load a result and stall it, then reset between edges.
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    checks++;
    if ({bus1.out_valid, bus1.c, bus1.s, bus1.carry_count} !== {1'b1, 1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL reset_precond: got v=%b c=%b s=%h n=%0d, want 1 1 0 1",
               bus1.out_valid, bus1.c, bus1.s, bus1.carry_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus1.out_valid, bus1.c, bus1.s, bus1.carry_count, bus1.in_ready} !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: got v=%b c=%b s=%h n=%0d rdy=%b, want 0 0 0 0 1",
               bus1.out_valid, bus1.c, bus1.s, bus1.carry_count, bus1.in_ready);
    end
    $display("txn reset mid-operation: v=%b n=%0d", bus1.out_valid, bus1.carry_count);
    do_reset();
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_cs [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
    logic [1:0] idx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      bus1.in_valid = 1'b1; bus1.a = idx[1]; bus1.b = idx[0]; bus1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus1.out_valid, bus1.c, bus1.s} !== {1'b1, exp_cs[i]}) begin
        errors++;
        $display("FAIL truth_%0d: got v=%b cs=%b%b, want v=1 cs=%b",
                 i, bus1.out_valid, bus1.c, bus1.s, exp_cs[i]);
      end
      $display("txn w1 a=%b b=%b -> c=%b s=%b", idx[1], idx[0], bus1.c, bus1.s);
    end
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.out_valid, bus1.carry_count} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL truth_end: got v=%b n=%0d, want v=0 n=1", bus1.out_valid, bus1.carry_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.a = 1'b0; bus1.b = 1'b1; bus1.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus1.out_valid, bus1.c, bus1.s, bus1.in_ready, bus1.carry_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd1}) begin
        errors++;
        $display("FAIL stall_%0d: got v=%b c=%b s=%b rdy=%b n=%0d, want 1 1 0 0 1",
                 i, bus1.out_valid, bus1.c, bus1.s, bus1.in_ready, bus1.carry_count);
      end
      @(posedge clk);
      #1;
    end
    bus1.out_ready = 1'b1;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1", bus1.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus1.out_valid, bus1.c, bus1.s, bus1.carry_count} !== {1'b1, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL stall_release: got v=%b cs=%b%b n=%0d, want 1 01 1",
               bus1.out_valid, bus1.c, bus1.s, bus1.carry_count);
    end
    $display("txn w1 a=0 b=1 after stall -> c=%b s=%b", bus1.c, bus1.s);
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus4.in_valid = 1'b1; bus4.a = 4'h3; bus4.b = 4'h4; bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus4.out_valid, bus4.c, bus4.s} !== {1'b1, 1'b0, 4'h7}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b c=%b s=%h, want 1 0 7", bus4.out_valid, bus4.c, bus4.s);
    end
    bus4.a = 4'h9; bus4.b = 4'h9;
    #1;
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 1", bus4.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus4.out_valid, bus4.c, bus4.s} !== {1'b1, 1'b1, 4'h2}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b c=%b s=%h, want 1 1 2", bus4.out_valid, bus4.c, bus4.s);
    end
    $display("txn w4 3+4 then 9+9 -> c=%b s=%h", bus4.c, bus4.s);
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    logic [3:0] ta [6] = '{4'hF, 4'h8, 4'h9, 4'hF, 4'hF, 4'h1};
    logic [3:0] tb [6] = '{4'h1, 4'h8, 4'h9, 4'hF, 4'h1, 4'h2};
    logic [3:0] es [6] = '{4'h0, 4'h0, 4'h2, 4'hE, 4'h0, 4'h3};
    logic       ec [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] en [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus4.in_valid = 1'b1; bus4.a = ta[i]; bus4.b = tb[i]; bus4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus4.out_valid, bus4.c, bus4.s, bus4.carry_count} !== {1'b1, ec[i], es[i], en[i]}) begin
        errors++;
        $display("FAIL sat_%0d: got v=%b c=%b s=%h n=%0d, want 1 %b %h %0d",
                 i, bus4.out_valid, bus4.c, bus4.s, bus4.carry_count, ec[i], es[i], en[i]);
      end
      $display("txn w4 %h+%h -> c=%b s=%h n=%0d", ta[i], tb[i], bus4.c, bus4.s, bus4.carry_count);
    end
    bus4.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int sum;
    int r1, r4;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus1.in_valid = 1'($urandom_range(0, 1));
      bus1.a = 1'($urandom_range(0, 1));
      bus1.b = 1'($urandom_range(0, 1));
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      bus4.in_valid = 1'($urandom_range(0, 1));
      bus4.a = 4'($urandom_range(0, 15));
      bus4.b = 4'($urandom_range(0, 15));
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      r1 = (m1_v == 0 || bus1.out_ready) ? 1 : 0;
      r4 = (m4_v == 0 || bus4.out_ready) ? 1 : 0;
      checks++;
      if ({bus1.in_ready, bus4.in_ready} !== {1'(r1), 1'(r4)}) begin
        errors++;
        $display("FAIL rand_ready_%0d: got %b%b want %0d%0d", i, bus1.in_ready, bus4.in_ready, r1, r4);
      end
      // Model: widened add, store result, count carries up to the counter max.
      if (bus1.in_valid && r1 == 1) begin
        sum = int'(bus1.a) + int'(bus1.b);
        m1_s = sum % 2; m1_c = sum / 2; m1_v = 1;
        if (m1_c == 1 && m1_n < 255) m1_n++;
        $display("txn w1 %0d+%0d -> c=%0d s=%0d", bus1.a, bus1.b, m1_c, m1_s);
      end else if (m1_v == 1 && bus1.out_ready) begin
        m1_v = 0;
      end
      if (bus4.in_valid && r4 == 1) begin
        sum = int'(bus4.a) + int'(bus4.b);
        m4_s = sum % 16; m4_c = sum / 16; m4_v = 1;
        if (m4_c == 1 && m4_n < 3) m4_n++;
        $display("txn w4 %0d+%0d -> c=%0d s=%0d", bus4.a, bus4.b, m4_c, m4_s);
      end else if (m4_v == 1 && bus4.out_ready) begin
        m4_v = 0;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus1.out_valid, bus1.c, bus1.s, bus1.carry_count} !== {1'(m1_v), 1'(m1_c), 1'(m1_s), 8'(m1_n)}) begin
        errors++;
        $display("FAIL rand_w1_%0d: got v=%b c=%b s=%b n=%0d, want v=%0d c=%0d s=%0d n=%0d",
                 i, bus1.out_valid, bus1.c, bus1.s, bus1.carry_count, m1_v, m1_c, m1_s, m1_n);
      end
      checks++;
      if ({bus4.out_valid, bus4.c, bus4.s, bus4.carry_count} !== {1'(m4_v), 1'(m4_c), 4'(m4_s), 2'(m4_n)}) begin
        errors++;
        $display("FAIL rand_w4_%0d: got v=%b c=%b s=%h n=%0d, want v=%0d c=%0d s=%0d n=%0d",
                 i, bus4.out_valid, bus4.c, bus4.s, bus4.carry_count, m4_v, m4_c, m4_s, m4_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
